// File: rtl/srlc32e_srl.sv
// 32-deep x 1-bit addressable shift register with clock enable (SRLC32E model).
// Synchronous active-low reset reloads INIT; q is a combinational tap sr[a].
module srlc32e_srl #(
  parameter logic [31:0] INIT = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       d,
  input  logic [4:0] a,
  output logic       q,
  output logic       q31
);

  // Power-up contents come from the declaration initialiser, matching the
  // FPGA primitive's configuration-time INIT load.
  logic [31:0] sr_q = INIT;
  logic [31:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (ce) sr_d = {sr_q[30:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sr_q <= INIT;
    else        sr_q <= sr_d;
  end

  // Every 5-bit address names a real stage, so the tap never goes X.
  assign q   = sr_q[a];
  assign q31 = sr_q[31];

endmodule

// File: tb/tb_srlc32e_srl.sv
// Self-checking bench for srlc32e_srl: directed steps plus randomized traffic
// checked against a queue-based shift-register model.
module tb_srlc32e_srl;
  localparam logic [31:0] INIT_A = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  // DUT A: non-zero INIT, checked against the queue model
  logic       rst_a = 1'b1, ce_a = 1'b0, d_a = 1'b0;
  logic [4:0] a_a = 5'd0;
  logic       q_a, q31_a;

  // DUT B: default INIT, used for delay-line and oscillator timing
  logic       rst_b = 1'b1, ce_b = 1'b0, dd_b = 1'b0, osc = 1'b0;
  logic [4:0] a_b = 5'd0;
  logic       d_b, q_b, q31_b;
  assign d_b = osc ? ~q_b : dd_b;

  srlc32e_srl #(.INIT(INIT_A)) u_a (
    .clk(clk), .rst_n(rst_a), .ce(ce_a), .d(d_a), .a(a_a), .q(q_a), .q31(q31_a)
  );
  srlc32e_srl u_b (
    .clk(clk), .rst_n(rst_b), .ce(ce_b), .d(d_b), .a(a_b), .q(q_b), .q31(q31_b)
  );

  int checks = 0;
  int errors = 0;
  // mq[i] holds stage i of DUT A
  logic mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_load();
    mq.delete();
    for (int i = 0; i < 32; i++) mq.push_back(INIT_A[i]);
  endtask

  // One rising edge; model A follows the same inputs the DUT samples.
  task automatic tick();
    @(posedge clk);
    if (!rst_a) model_load();
    else if (ce_a) begin
      mq.push_front(d_a);
      void'(mq.pop_back());
    end
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      a_a = 5'(i);
      #1;
      chk(tag, 32'(q_a), 32'(mq[i]));
    end
  endtask

  initial begin
    model_load();
    #1;
    sweep("powerup");

    // Reset priority: ce=1 and d=1 on the reset edge must not be captured
    rst_a = 1'b0; ce_a = 1'b1; d_a = 1'b1;
    tick();
    rst_a = 1'b1; ce_a = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a_a = 5'(i);
      #1;
      chk("rst_load", 32'(q_a), 32'(INIT_A[i]));
    end
    chk("rst_q31", 32'(q31_a), 32'd1);

    // CE gating: load 1011, hold for 10 edges while d toggles, then resume
    ce_a = 1'b1;
    d_a = 1'b1; tick();
    d_a = 1'b0; tick();
    d_a = 1'b1; tick();
    d_a = 1'b1; tick();
    ce_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d_a = ~d_a;
      tick();
    end
    a_a = 5'd3; #1; chk("ce_nib3", 32'(q_a), 32'd1);
    a_a = 5'd2; #1; chk("ce_nib2", 32'(q_a), 32'd0);
    a_a = 5'd1; #1; chk("ce_nib1", 32'(q_a), 32'd1);
    a_a = 5'd0; #1; chk("ce_nib0", 32'(q_a), 32'd1);
    sweep("ce_hold");
    ce_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_a = 1'(i);
      tick();
    end
    ce_a = 1'b0;
    sweep("ce_resume");

    // Async tap read of sr = 32'h8000_0001 with no clock edge between reads
    ce_a = 1'b1;
    for (int i = 0; i < 32; i++) begin
      d_a = (i == 0 || i == 31);
      tick();
    end
    ce_a = 1'b0;
    a_a = 5'd0;  #1; chk("tap_a0",  32'(q_a), 32'd1);
    a_a = 5'd1;  #1; chk("tap_a1",  32'(q_a), 32'd0);
    a_a = 5'd31; #1; chk("tap_a31", 32'(q_a), 32'd1);
    chk("tap_q31", 32'(q31_a), 32'd1);

    // Randomized traffic against the queue model
    repeat (300) begin
      d_a   = 1'($urandom);
      ce_a  = ($urandom % 5) != 0;
      rst_a = ($urandom % 20) != 0;
      tick();
      a_a = 5'($urandom);
      #1;
      chk("rand_q", 32'(q_a), 32'(mq[a_a]));
      chk("rand_q31", 32'(q31_a), 32'(mq[31]));
    end
    rst_a = 1'b1; ce_a = 1'b0;

    // Delay line: single-cycle pulse reaches tap a after a+1 edges
    for (int av = 0; av < 32; av += 31) begin
      a_b = 5'(av);
      rst_b = 1'b0; ce_b = 1'b1; dd_b = 1'b0;
      tick();
      rst_b = 1'b1;
      chk("dly_rst", 32'(q_b), 32'd0);
      dd_b = 1'b1;
      tick();
      dd_b = 1'b0;
      chk("dly_k0", 32'(q_b), 32'(av == 0));
      for (int k = 1; k <= 40; k++) begin
        tick();
        chk("dly_k", 32'(q_b), 32'(k == av));
      end
    end

    // Oscillator: d=~q at a=31 gives q = (edges/32) mod 2; reset restarts it
    a_b = 5'd31; ce_b = 1'b1; rst_b = 1'b0;
    tick();
    rst_b = 1'b1; osc = 1'b1;
    chk("osc_start", 32'(q_b), 32'd0);
    for (int n = 1; n <= 140; n++) begin
      tick();
      chk("osc_run", 32'(q_b), 32'((n / 32) % 2));
    end
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    chk("osc_rst", 32'(q_b), 32'd0);
    chk("osc_rst_q31", 32'(q31_b), 32'd0);
    for (int n = 1; n <= 100; n++) begin
      tick();
      chk("osc_rerun", 32'(q_b), 32'((n / 32) % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
